// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: runs one counter + shift-register pass per accepted command
// and returns the terminal count and the captured shift word on a valid/ready port.
// All outputs come straight from flops; next values are computed in one
// combinational block from the next state and next run index.
module cnt_seq_ctrl #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_min,
    input  logic [3:0] cmd_max,
    input  logic       cmd_mode,
    input  logic [3:0] cmd_word,
    input  logic       abort,
    output logic       cnt_rst,
    output logic       cnt_ss,
    output logic       cnt_mode,
    output logic [3:0] cnt_min,
    output logic [3:0] cnt_max,
    input  logic [3:0] cnt_out,
    output logic       sh_in,
    input  logic [3:0] sh_q,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_count,
    output logic [3:0] res_word,
    output logic [1:0] res_status,
    output logic       busy
);

    localparam int unsigned DW = 4;
    localparam int unsigned KW = 5;
    localparam int unsigned SW = 3;
    localparam int unsigned STW = 2;

    localparam logic [SW-1:0] S_IDLE = 3'd0;
    localparam logic [SW-1:0] S_CLR  = 3'd1;
    localparam logic [SW-1:0] S_RUN  = 3'd2;
    localparam logic [SW-1:0] S_STOP = 3'd3;
    localparam logic [SW-1:0] S_DONE = 3'd4;

    localparam logic [STW-1:0] ST_OK      = 2'b00;
    localparam logic [STW-1:0] ST_RANGE   = 2'b01;
    localparam logic [STW-1:0] ST_TIMEOUT = 2'b10;

    localparam logic [KW-1:0] K_SAT = '1;

    // state and run context
    logic [SW-1:0]  state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [DW-1:0]  word_q, word_d;

    // registered outputs
    logic           cmd_ready_q, cmd_ready_d;
    logic           busy_q, busy_d;
    logic           cnt_rst_q, cnt_rst_d;
    logic           cnt_ss_q, cnt_ss_d;
    logic           cnt_mode_q, cnt_mode_d;
    logic [DW-1:0]  cnt_min_q, cnt_min_d;
    logic [DW-1:0]  cnt_max_q, cnt_max_d;
    logic           sh_in_q, sh_in_d;
    logic           res_valid_q, res_valid_d;
    logic [DW-1:0]  res_count_q, res_count_d;
    logic [DW-1:0]  res_word_q, res_word_d;
    logic [STW-1:0] res_status_q, res_status_d;

    logic [DW-1:0]  terminal;
    logic [1:0]     bit_sel;

    // state and run-context register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
        end
    end

    // output registers; cnt_rst is held high while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            cnt_rst_q    <= 1'b1;
            cnt_ss_q     <= 1'b0;
            cnt_mode_q   <= 1'b0;
            cnt_min_q    <= '0;
            cnt_max_q    <= '0;
            sh_in_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            res_count_q  <= '0;
            res_word_q   <= '0;
            res_status_q <= ST_OK;
        end else begin
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            cnt_rst_q    <= cnt_rst_d;
            cnt_ss_q     <= cnt_ss_d;
            cnt_mode_q   <= cnt_mode_d;
            cnt_min_q    <= cnt_min_d;
            cnt_max_q    <= cnt_max_d;
            sh_in_q      <= sh_in_d;
            res_valid_q  <= res_valid_d;
            res_count_q  <= res_count_d;
            res_word_q   <= res_word_d;
            res_status_q <= res_status_d;
        end
    end

    // next-state, run index and next output values
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        word_d       = word_q;
        cnt_mode_d   = cnt_mode_q;
        cnt_min_d    = cnt_min_q;
        cnt_max_d    = cnt_max_q;
        res_count_d  = res_count_q;
        res_word_d   = res_word_q;
        res_status_d = res_status_q;
        bit_sel      = 2'b00;

        // counter configuration is stable from CLR onward, so it supplies the terminal
        terminal = cnt_mode_q ? cnt_min_q : cnt_max_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    word_d = cmd_word;
                    if (cmd_min > cmd_max) begin
                        state_d      = S_DONE;
                        res_count_d  = '0;
                        res_word_d   = '0;
                        res_status_d = ST_RANGE;
                    end else begin
                        state_d    = S_CLR;
                        cnt_min_d  = cmd_min;
                        cnt_max_d  = cmd_max;
                        cnt_mode_d = cmd_mode;
                    end
                end
            end
            S_CLR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if ((k_q != '0) && (cnt_out == terminal)) begin
                    state_d     = S_STOP;
                    res_count_d = cnt_out;
                end else if (32'(k_q) == TIMEOUT) begin
                    state_d      = S_DONE;
                    res_count_d  = cnt_out;
                    res_status_d = ST_TIMEOUT;
                end else if (k_q != K_SAT) begin
                    k_d = k_q + KW'(1);
                end
            end
            S_STOP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d      = S_DONE;
                    res_word_d   = sh_q;
                    res_status_d = ST_OK;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // word is sent MSB first: bit index 3 - (k mod 4) is the inverse of k[1:0]
        bit_sel     = ~k_d[1:0];
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        cnt_rst_d   = (state_d == S_CLR);
        cnt_ss_d    = (state_d == S_RUN);
        sh_in_d     = (state_d == S_RUN) ? word_d[bit_sel] : 1'b0;
        res_valid_d = (state_d == S_DONE);
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign cnt_rst    = cnt_rst_q;
    assign cnt_ss     = cnt_ss_q;
    assign cnt_mode   = cnt_mode_q;
    assign cnt_min    = cnt_min_q;
    assign cnt_max    = cnt_max_q;
    assign sh_in      = sh_in_q;
    assign res_valid  = res_valid_q;
    assign res_count  = res_count_q;
    assign res_word   = res_word_q;
    assign res_status = res_status_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: behavioural counter and shift register around the DUT,
// expected results queued when a command is issued and checked when res_valid rises.
module tb_cnt_seq_ctrl;

    localparam int TMO = 31;

    typedef struct packed {
        logic [3:0] count;
        logic [3:0] word;
        logic [1:0] status;
    } res_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_min;
    logic [3:0] cmd_max;
    logic       cmd_mode;
    logic [3:0] cmd_word;
    logic       abort;
    logic       cnt_rst;
    logic       cnt_ss;
    logic       cnt_mode;
    logic [3:0] cnt_min;
    logic [3:0] cnt_max;
    logic [3:0] cnt_out;
    logic       sh_in;
    logic [3:0] sh_q;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_count;
    logic [3:0] res_word;
    logic [1:0] res_status;
    logic       busy;

    logic [3:0] cnt_m;
    logic       force_zero;
    logic [3:0] prev_word;

    int   n_cmp;
    int   n_err;
    res_t exp_q[$];

    cnt_seq_ctrl #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_min    (cmd_min),
        .cmd_max    (cmd_max),
        .cmd_mode   (cmd_mode),
        .cmd_word   (cmd_word),
        .abort      (abort),
        .cnt_rst    (cnt_rst),
        .cnt_ss     (cnt_ss),
        .cnt_mode   (cnt_mode),
        .cnt_min    (cnt_min),
        .cnt_max    (cnt_max),
        .cnt_out    (cnt_out),
        .sh_in      (sh_in),
        .sh_q       (sh_q),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_word   (res_word),
        .res_status (res_status),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural MIN/MAX counter
    always_ff @(posedge clk) begin
        if (cnt_rst)
            cnt_m <= cnt_mode ? cnt_max : cnt_min;
        else if (cnt_ss)
            cnt_m <= cnt_mode ? cnt_m - 4'd1 : cnt_m + 4'd1;
    end
    assign cnt_out = force_zero ? 4'd0 : cnt_m;

    // behavioural serial-in shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sh_q <= 4'd0;
        else      sh_q <= {sh_q[2:0], sh_in};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference result and latency (edges after acceptance) for one command
    function automatic void ref_model(input logic [3:0] mn, input logic [3:0] mx, input logic md,
                                      input logic [3:0] w, input logic f0, input logic [3:0] pw,
                                      output res_t r, output int lat);
        logic [3:0] c;
        logic [3:0] term;
        logic [3:0] q;
        logic [3:0] obs;
        logic [1:0] sel;
        r   = '0;
        lat = 0;
        if (mn > mx) begin
            r.status = 2'b01;
            lat      = 1;
            return;
        end
        c    = md ? mx : mn;
        term = md ? mn : mx;
        q    = 4'd0;
        for (int k = 0; k <= TMO; k++) begin
            obs = f0 ? 4'd0 : c;
            sel = 2'(3 - (k % 4));
            q   = {q[2:0], w[sel]};
            if (k >= 1 && obs == term) begin
                r.count  = obs;
                r.word   = q;
                r.status = 2'b00;
                lat      = 4 + k;
                return;
            end
            if (k == TMO) begin
                r.count  = obs;
                r.word   = pw;
                r.status = 2'b10;
                lat      = 3 + k;
                return;
            end
            c = md ? c - 4'd1 : c + 4'd1;
        end
    endfunction

    // issue one command, wait for the result, hold it for 'hold' cycles, then accept it
    task automatic run_cmd(input logic [3:0] mn, input logic [3:0] mx, input logic md,
                           input logic [3:0] w, input int hold,
                           output int n_rst, output int n_ss, output logic [31:0] seq);
        res_t e;
        int   elat;
        int   cyc;
        int   waitc;
        n_rst = 0;
        n_ss  = 0;
        seq   = '0;
        waitc = 0;
        while (!cmd_ready && waitc < 64) begin
            step();
            waitc++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        ref_model(mn, mx, md, w, force_zero, prev_word, e, elat);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_min   = mn;
        cmd_max   = mx;
        cmd_mode  = md;
        cmd_word  = w;
        cyc = 0;
        do begin
            step();
            cyc++;
            cmd_valid = 1'b0;
            if (cnt_rst) n_rst++;
            if (cnt_ss) begin
                n_ss++;
                seq = {seq[30:0], sh_in};
            end
        end while (!res_valid && cyc < 64);
        chk("latency", 32'(cyc), 32'(elat));
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            prev_word = e.word;
            chk("res_count", 32'(res_count), 32'(e.count));
            chk("res_word", 32'(res_word), 32'(e.word));
            chk("res_status", 32'(res_status), 32'(e.status));
            for (int i = 0; i < hold; i++) begin
                if (i == 1) begin
                    cmd_valid = 1'b1;
                    cmd_min   = 4'd1;
                    cmd_max   = 4'd2;
                    abort     = 1'b1;
                end
                if (i == hold - 1) begin
                    cmd_valid = 1'b0;
                    abort     = 1'b0;
                end
                step();
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_count", 32'(res_count), 32'(e.count));
                chk("hold_word", 32'(res_word), 32'(e.word));
                chk("hold_status", 32'(res_status), 32'(e.status));
                chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_hs_valid", 32'(res_valid), 32'd0);
        step();
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid2", 32'(res_valid), 32'd0);
    endtask

    // start an up run (9..14) and stop at RUN index 3
    task automatic start_to_k3();
        int waitc;
        waitc = 0;
        while (!cmd_ready && waitc < 64) begin
            step();
            waitc++;
        end
        cmd_valid = 1'b1;
        cmd_min   = 4'd9;
        cmd_max   = 4'd14;
        cmd_mode  = 1'b0;
        cmd_word  = 4'b1011;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("k3_cnt_ss", 32'(cnt_ss), 32'd1);
        chk("k3_cnt_out", 32'(cnt_out), 32'd12);
    endtask

    initial begin
        int          nr;
        int          ns;
        logic [31:0] seq;
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_min    = 4'd0;
        cmd_max    = 4'd0;
        cmd_mode   = 1'b0;
        cmd_word   = 4'd0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        force_zero = 1'b0;
        prev_word  = 4'd0;

        // reset values
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt_rst", 32'(cnt_rst), 32'd1);
        chk("rst_cnt_ss", 32'(cnt_ss), 32'd0);
        chk("rst_sh_in", 32'(sh_in), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_fields", 32'({res_count, res_word, res_status}), 32'd0);
        chk("rst_cnt_cfg", 32'({cnt_min, cnt_max, cnt_mode}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_cnt_rst", 32'(cnt_rst), 32'd0);

        // up run
        run_cmd(4'd9, 4'd14, 1'b0, 4'b1011, 0, nr, ns, seq);
        chk("up_n_rst", 32'(nr), 32'd1);
        chk("up_n_ss", 32'(ns), 32'd6);
        chk("up_sh_seq", seq, 32'b101110);
        chk("up_cfg", 32'({cnt_min, cnt_max, cnt_mode}), 32'({4'd9, 4'd14, 1'b0}));

        // timeout with the counter output stuck at zero
        force_zero = 1'b1;
        run_cmd(4'd9, 4'd14, 1'b0, 4'b1011, 0, nr, ns, seq);
        force_zero = 1'b0;
        chk("to_n_ss", 32'(ns), 32'(TMO + 1));

        // down run with result backpressure
        run_cmd(4'd9, 4'd14, 1'b1, 4'b1011, 5, nr, ns, seq);
        chk("dn_n_ss", 32'(ns), 32'd6);
        chk("dn_sh_seq", seq, 32'b101110);

        // range error leaves the counter untouched
        run_cmd(4'd12, 4'd3, 1'b0, 4'b1011, 0, nr, ns, seq);
        chk("re_n_rst", 32'(nr), 32'd0);
        chk("re_n_ss", 32'(ns), 32'd0);
        chk("re_cfg", 32'({cnt_min, cnt_max, cnt_mode}), 32'({4'd9, 4'd14, 1'b1}));

        // min == max: terminal only after a full wrap
        run_cmd(4'd5, 4'd5, 1'b0, 4'b0110, 0, nr, ns, seq);
        chk("eq_n_ss", 32'(ns), 32'd17);

        // asynchronous reset at RUN index 3
        start_to_k3();
        #1 rst = 1'b0;
        #1;
        chk("arst_cnt_ss", 32'(cnt_ss), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_cnt_rst", 32'(cnt_rst), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_no_result", 32'(res_valid), 32'd0);
            chk("arst_idle", 32'(busy), 32'd0);
        end

        // abort at RUN index 3
        start_to_k3();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt_ss", 32'(cnt_ss), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        repeat (2) step();
        chk("abort_no_result", 32'(res_valid), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Sequencer that drives one run of the 4-bit MIN/MAX counter and the 4-bit serial-in shift register from a single command. For each accepted command it:
- clears and configures the counter, then starts it;
- streams a 4-bit pattern serially into the shift register while the counter runs to its terminal value;
- stops both and returns the final count and the captured parallel word over a valid/ready result port.

It sits between the host-side command logic and the counter and shift-register datapath.

## Interface
Parameters:
- TIMEOUT, 31: last allowed RUN-cycle index k. Exceeding it aborts the run with a timeout.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_min  in  4  counter MIN
- cmd_max  in  4  counter MAX
- cmd_mode  in  1  0 = count up, 1 = count down
- cmd_word  in  4  pattern to shift, MSB first
- abort  in  1  synchronous abort
- cnt_rst  out  1  counter reset (active-high)
- cnt_ss  out  1  counter start/stop
- cnt_mode  out  1  counter MODE
- cnt_min  out  4  counter MIN
- cnt_max  out  4  counter MAX
- cnt_out  in  4  counter value
- sh_in  out  1  shift-register serial input
- sh_q  in  4  shift-register parallel output
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_count  out  4  final count
- res_word  out  4  captured shift word
- res_status  out  2  00 = ok, 01 = range error, 10 = timeout
- busy  out  1  high whenever state ≠ IDLE

## Operation
States: IDLE, CLR, RUN, STOP, DONE.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid, latch min, max, mode and word.
  - If min > max (unsigned): go to DONE with res_status = 01 and res_count = res_word = 0. The counter is untouched.
  - Otherwise go to CLR.
- **CLR** (1 cycle)
  - cnt_rst = 1, cnt_ss = 0.
  - cnt_min, cnt_max and cnt_mode present the latched values from CLR until the next command.
  - Clear k. Go to RUN.
- **RUN**
  - cnt_ss = 1.
  - sh_in = word[3 − (k mod 4)].
  - k increments every cycle.
  - Terminal value is max when mode = 0 and min when mode = 1.
  - If k ≥ 1 and cnt_out == terminal: capture cnt_out into res_count and go to STOP.
  - Otherwise, if k == TIMEOUT: capture cnt_out into res_count, set res_status = 10, and go to DONE.
- **STOP** (1 cycle)
  - cnt_ss = 0, sh_in = 0.
  - Capture sh_q into res_word, set res_status = 00, go to DONE.
- **DONE**
  - res_valid = 1. Results are held stable until res_valid && res_ready, then go to IDLE.
  - cmd_valid is ignored.
- **abort**: in CLR, RUN or STOP, go to IDLE next cycle with cnt_ss = 0 and no result. abort is ignored in IDLE and DONE.
- k is a 5-bit counter and saturates; it never wraps.

## Timing
- Reset (rst low) takes effect immediately, asynchronously:
  - state = IDLE, cmd_ready = 1, busy = 0;
  - cnt_rst = 1 while rst is low, 0 after release;
  - cnt_ss = 0, sh_in = 0, res_valid = 0;
  - res_count, res_word, res_status, cnt_min, cnt_max and cnt_mode all = 0.
- A reset during any state discards the run.
- Command accepted on edge T:
  - CLR occupies cycle T+1;
  - RUN starts at T+2, with k = 0 at T+2;
  - a terminal detected at RUN index k gives STOP at T+3+k and res_valid at T+4+k.
- Range error: res_valid at T+1.
- Timeout: res_valid at T+3+TIMEOUT; res_word holds its previous value.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The result handshake completes on the edge where res_valid && res_ready. cmd_ready rises in the following cycle.

## Test plan
The bench uses a behavioural counter and shift-register model:
- the counter loads MIN (up) or MAX (down) on cnt_rst and steps ±1 on each clk while cnt_ss = 1;
- the shift register updates Q <= {Q[2:0], In} on every edge.

Scenarios:
- **Up run**: min = 9, max = 14, mode = 0, word = 4'b1011 accepted at T -> RUN T+2..T+7, sh_in sequence 1,0,1,1,1,0, res_valid at T+9 with res_count = 14, res_word = 4'b1110, res_status = 00.
- **Down run**: same command with mode = 1 -> res_count = 9, res_valid at T+9, res_status = 00.
- **Range error**: min = 12, max = 3 -> res_valid at T+1, res_status = 01, cnt_rst and cnt_ss never assert.
- **Timeout**: model cnt_out forced to 0, min = 9, max = 14, TIMEOUT = 31 -> res_valid at T+34, res_status = 10.
- **Backpressure**: res_ready low for 5 cycles after res_valid -> all results stable, cmd_ready = 0, a new cmd_valid is ignored; after the handshake, cmd_ready = 1 in the next cycle.
- **Reset and abort**:
  - rst low at RUN k = 3 -> cnt_ss = 0 and busy = 0 immediately, res_valid stays 0.
  - A repeat run with abort at k = 3 -> IDLE one cycle later with no result.
